// File: rtl/clefia_pkg.sv
// Shared CLEFIA constants: round-key counts per key size, the sequencer FSM
// state encoding and the whitening-key slot indices.
package clefia_pkg;

    localparam int NUM_RK_128 = 36;
    localparam int NUM_RK_192 = 44;
    localparam int NUM_RK_256 = 52;

    localparam int WK0_IDX = 0;
    localparam int WK1_IDX = 1;
    localparam int WK2_IDX = 2;
    localparam int WK3_IDX = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_LOADED = 2'd2,
        ST_STREAM = 2'd3
    } rk_state_e;

    // Round keys in one schedule for a given key length in bits.
    function automatic int rk_count(input int key_bits);
        case (key_bits)
            192:     return NUM_RK_192;
            256:     return NUM_RK_256;
            default: return NUM_RK_128;
        endcase
    endfunction

endpackage

// File: rtl/rk_sequencer_if.sv
// Round-key write port (from key expansion) and round-key stream (to the
// data path). The master modport is the sequencer side.
interface rk_sequencer_if;

    logic        rk_wr_valid;
    logic [31:0] rk_wr_data;
    logic        rk_wr_ready;
    logic [31:0] rk_out;
    logic        rk_valid;
    logic        rk_ready;

    modport master (
        input  rk_wr_valid, rk_wr_data, rk_ready,
        output rk_wr_ready, rk_out, rk_valid
    );

    modport slave (
        output rk_wr_valid, rk_wr_data, rk_ready,
        input  rk_wr_ready, rk_out, rk_valid
    );

endinterface

// File: rtl/rk_regfile.sv
// Round-key storage: DEPTH x 32 registers, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module rk_regfile #(
    parameter int DEPTH = 36,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/rk_sequencer.sv
// CLEFIA round-key sequencer: buffers one key schedule and streams it in
// encrypt or decrypt order. Decrypt ordering exists only with RK_SEQ_DECRYPT_EN.
module rk_sequencer
    import clefia_pkg::*;
#(
    parameter int NUM_RK = NUM_RK_128,
    parameter int AW     = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [127:0]          wk_in,
    input  logic                  wk_load,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic                  clear,
    rk_sequencer_if.master        bus,
    output logic [31:0]           wk0_out,
    output logic [31:0]           wk1_out,
    output logic                  busy,
    output logic                  done,
    output logic                  load_err
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_RK - 1);

    rk_state_e     state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] count;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_data;
    logic [31:0]   wk_reg [4];
    logic          mode;
    logic          after_final;
    logic          in_load_phase;
    logic          wr_fire;
    logic          hi_pair;

    assign in_load_phase = (state == ST_IDLE) || (state == ST_LOAD);
    assign wr_fire       = bus.rk_wr_valid && in_load_phase && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            count       <= '0;
            after_final <= 1'b0;
            done        <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            if (clear) begin
                state       <= ST_IDLE;
                wr_ptr      <= '0;
                count       <= '0;
                after_final <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_LOAD: begin
                        if (start) load_err <= 1'b1;
                        if (wr_fire) begin
                            wr_ptr <= wr_ptr + AW'(1);
                            state  <= (wr_ptr == LAST_IDX) ? ST_LOADED : ST_LOAD;
                        end
                    end
                    ST_LOADED: begin
                        if (start) begin
                            state       <= ST_STREAM;
                            count       <= '0;
                            after_final <= 1'b0;
                        end
                    end
                    ST_STREAM: begin
                        if (bus.rk_ready) begin
                            if (count == LAST_IDX) begin
                                // Keys stay in place so the next block can restart at once.
                                state       <= ST_LOADED;
                                count       <= '0;
                                done        <= 1'b1;
                                after_final <= 1'b1;
                            end else begin
                                count <= count + AW'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef RK_SEQ_DECRYPT_EN
    localparam logic [AW-1:0] DEC_BASE = AW'(NUM_RK - 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 1'b0;
        end else if (!clear && state == ST_LOADED && start) begin
            mode <= decrypt;
        end
    end

    // Decrypt walks key pairs from the top down, keeping each pair in order.
    assign rd_idx = mode ? (DEC_BASE - {count[AW-1:1], 1'b0} + {{(AW-1){1'b0}}, count[0]})
                         : count;
`else
    logic decrypt_unused;
    assign decrypt_unused = decrypt;
    assign mode           = 1'b0;
    assign rd_idx         = count;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) wk_reg[i] <= '0;
        end else if (wk_load && state != ST_STREAM) begin
            wk_reg[WK0_IDX] <= wk_in[127:96];
            wk_reg[WK1_IDX] <= wk_in[95:64];
            wk_reg[WK2_IDX] <= wk_in[63:32];
            wk_reg[WK3_IDX] <= wk_in[31:0];
        end
    end

    rk_regfile #(
        .DEPTH (NUM_RK),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .we      (wr_fire),
        .wr_idx  (wr_ptr),
        .wr_data (bus.rk_wr_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign bus.rk_wr_ready = in_load_phase;
    assign bus.rk_valid    = (state == ST_STREAM);
    assign bus.rk_out      = bus.rk_valid ? rd_data : '0;
    assign busy            = (state == ST_STREAM);

    // The pair flips once the final key of a block has been accepted.
    assign hi_pair = !in_load_phase && (mode ^ after_final);
    assign wk0_out = hi_pair ? wk_reg[WK2_IDX] : wk_reg[WK0_IDX];
    assign wk1_out = hi_pair ? wk_reg[WK3_IDX] : wk_reg[WK1_IDX];

endmodule

// File: tb/tb_rk_sequencer.sv
// Self-checking bench for rk_sequencer: a schedule-level reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_rk_sequencer;

    localparam int NUM_RK = 36;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic [127:0] wk_in   = '0;
    logic         wk_load = 1'b0;
    logic         start   = 1'b0;
    logic         decrypt = 1'b0;
    logic         clear   = 1'b0;
    logic [31:0]  wk0_out;
    logic [31:0]  wk1_out;
    logic         busy;
    logic         done;
    logic         load_err;

    rk_sequencer_if intf();

    rk_sequencer #(
        .NUM_RK (NUM_RK),
        .AW     (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wk_in    (wk_in),
        .wk_load  (wk_load),
        .start    (start),
        .decrypt  (decrypt),
        .clear    (clear),
        .bus      (intf),
        .wk0_out  (wk0_out),
        .wk1_out  (wk1_out),
        .busy     (busy),
        .done     (done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: tracks what has been loaded and where the stream is.
    logic [31:0] m_keys [NUM_RK];
    logic [31:0] m_wk   [4];
    int          m_wrcnt;
    int          m_pos;
    bit          m_loaded, m_stream, m_dec, m_after, m_done, m_err;

    function automatic logic [31:0] exp_key(input int pos, input bit dec);
        int p;
        if (!dec) return m_keys[pos];
        p = NUM_RK / 2 - 1 - pos / 2;
        return m_keys[2 * p + pos % 2];
    endfunction

    function automatic logic [31:0] exp_wk(input int slot);
        bit hi;
        hi = (m_loaded || m_stream) && (m_dec ^ m_after);
        return m_wk[hi ? slot + 2 : slot];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wrcnt  <= 0;
            m_pos    <= 0;
            m_loaded <= 1'b0;
            m_stream <= 1'b0;
            m_dec    <= 1'b0;
            m_after  <= 1'b0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
            for (int i = 0; i < 4; i++) m_wk[i] <= '0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (wk_load && !m_stream) begin
                m_wk[0] <= wk_in[127:96];
                m_wk[1] <= wk_in[95:64];
                m_wk[2] <= wk_in[63:32];
                m_wk[3] <= wk_in[31:0];
            end
            if (clear) begin
                m_stream <= 1'b0;
                m_loaded <= 1'b0;
                m_wrcnt  <= 0;
                m_pos    <= 0;
                m_after  <= 1'b0;
            end else if (m_stream) begin
                if (intf.rk_ready) begin
                    if (m_pos == NUM_RK - 1) begin
                        m_stream <= 1'b0;
                        m_loaded <= 1'b1;
                        m_done   <= 1'b1;
                        m_after  <= 1'b1;
                        m_pos    <= 0;
                    end else begin
                        m_pos <= m_pos + 1;
                    end
                end
            end else if (m_loaded) begin
                if (start) begin
                    m_stream <= 1'b1;
                    m_pos    <= 0;
                    m_after  <= 1'b0;
`ifdef RK_SEQ_DECRYPT_EN
                    m_dec    <= decrypt;
`else
                    m_dec    <= 1'b0;
`endif
                end
            end else begin
                if (start) m_err <= 1'b1;
                if (intf.rk_wr_valid) begin
                    m_keys[m_wrcnt] <= intf.rk_wr_data;
                    m_wrcnt         <= m_wrcnt + 1;
                    if (m_wrcnt == NUM_RK - 1) m_loaded <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("rk_valid",    32'(intf.rk_valid),    32'(m_stream));
            checkOutput("rk_out",      intf.rk_out,           m_stream ? exp_key(m_pos, m_dec) : 32'h0);
            checkOutput("busy",        32'(busy),             32'(m_stream));
            checkOutput("done",        32'(done),             32'(m_done));
            checkOutput("load_err",    32'(load_err),         32'(m_err));
            checkOutput("rk_wr_ready", 32'(intf.rk_wr_ready), 32'(!m_loaded && !m_stream));
            checkOutput("wk0_out",     wk0_out,               exp_wk(0));
            checkOutput("wk1_out",     wk1_out,               exp_wk(1));
        end
    end

    task automatic applyStimulus(input bit wv, input logic [31:0] wd, input bit st, input bit dec,
                                 input bit clr, input bit rdy, input bit wkl, input logic [127:0] wki);
        @(posedge clk);
        #1;
        intf.rk_wr_valid = wv;
        intf.rk_wr_data  = wd;
        start            = st;
        decrypt          = dec;
        clear            = clr;
        intf.rk_ready    = rdy;
        wk_load          = wkl;
        wk_in            = wki;
    endtask

    task automatic idleCycle(input bit rdy);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, rdy, 1'b0, 128'h0);
    endtask

    task automatic loadKeys(input int first, input int n);
        for (int i = first; i < first + n; i++)
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0);
    endtask

    logic [31:0] obs [$];
    logic [31:0] first_wk0, post_wk0, post_wk1;
    int          ntx, ndone;

    // Start a block and follow it until done, or until stop_at transfers are seen.
    task automatic runStream(input bit dec, input bit toggle, input int stop_at);
        bit got_first;
        obs.delete();
        ntx       = 0;
        ndone     = 0;
        got_first = 1'b0;
        first_wk0 = 'x;
        applyStimulus(1'b0, 32'h0, 1'b1, dec, 1'b0, 1'b1, 1'b0, 128'h0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (intf.rk_valid && !got_first) begin
                first_wk0 = wk0_out;
                got_first = 1'b1;
            end
            if (intf.rk_valid && intf.rk_ready) begin
                obs.push_back(intf.rk_out);
                ntx++;
            end
            if (done) begin
                ndone++;
                post_wk0 = wk0_out;
                post_wk1 = wk1_out;
                break;
            end
            if (ntx == stop_at) break;
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, toggle ? bit'(cyc % 2) : 1'b1,
                          cyc == 3, 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0);
        end
    endtask

    int bad;

    initial begin
        intf.rk_wr_valid = 1'b0;
        intf.rk_wr_data  = '0;
        intf.rk_ready    = 1'b0;

        #23;
        checkOutput("reset_wr_ready", 32'(intf.rk_wr_ready), 32'd1);
        checkOutput("reset_rk_valid", 32'(intf.rk_valid),    32'd0);
        checkOutput("reset_rk_out",   intf.rk_out,           32'h0);
        checkOutput("reset_wk0",      wk0_out,               32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {32'hA0, 32'hA1, 32'hA2, 32'hA3});

        // Early start after 10 writes.
        loadKeys(0, 10);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0);
        idleCycle(1'b0);
        @(negedge clk);
        checkOutput("early_load_err", 32'(load_err),         32'd1);
        checkOutput("early_in_load",  32'(intf.rk_wr_ready), 32'd1);
        idleCycle(1'b0);
        @(negedge clk);
        checkOutput("early_err_pulse", 32'(load_err), 32'd0);
        loadKeys(10, 26);
        idleCycle(1'b0);
        @(negedge clk);
        checkOutput("loaded_wr_ready", 32'(intf.rk_wr_ready), 32'd0);
        checkOutput("loaded_wk0",      wk0_out,               32'hA0);

        // Encrypt stream, no backpressure.
        runStream(1'b0, 1'b0, -1);
        checkOutput("enc_ntx",      32'(ntx),   32'd36);
        checkOutput("enc_done_cnt", 32'(ndone), 32'd1);
        checkOutput("enc_first",    obs[0],     32'h100);
        checkOutput("enc_last",     obs[35],    32'h123);
        checkOutput("enc_wk_pre",   first_wk0,  32'hA0);
        checkOutput("enc_wk0_post", post_wk0,   32'hA2);
        checkOutput("enc_wk1_post", post_wk1,   32'hA3);
        idleCycle(1'b1);
        @(negedge clk);
        checkOutput("enc_done_once", 32'(done), 32'd0);

        // Backpressure on a second block without reloading.
        runStream(1'b0, 1'b1, -1);
        bad = 0;
        foreach (obs[i]) if (obs[i] !== 32'h100 + 32'(i)) bad++;
        checkOutput("bp_ntx",   32'(ntx), 32'd36);
        checkOutput("bp_order", 32'(bad), 32'd0);
        idleCycle(1'b1);

        // Decrypt request.
        runStream(1'b1, 1'b0, -1);
        checkOutput("dec_ntx", 32'(ntx), 32'd36);
`ifdef RK_SEQ_DECRYPT_EN
        checkOutput("dec_out0",  obs[0],    32'h122);
        checkOutput("dec_out1",  obs[1],    32'h123);
        checkOutput("dec_out2",  obs[2],    32'h120);
        checkOutput("dec_out3",  obs[3],    32'h121);
        checkOutput("dec_out34", obs[34],   32'h100);
        checkOutput("dec_out35", obs[35],   32'h101);
        checkOutput("dec_wk_pre",  first_wk0, 32'hA2);
        checkOutput("dec_wk_post", post_wk0,  32'hA0);
`else
        checkOutput("dec_ignored_first", obs[0],    32'h100);
        checkOutput("dec_ignored_wk",    first_wk0, 32'hA0);
`endif
        idleCycle(1'b1);

        // Abort at transfer 5 with clear and start together.
        runStream(1'b0, 1'b0, 5);
        checkOutput("abort_ntx", 32'(ntx), 32'd5);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0);
        idleCycle(1'b1);
        @(negedge clk);
        checkOutput("abort_rk_valid", 32'(intf.rk_valid),    32'd0);
        checkOutput("abort_wr_ready", 32'(intf.rk_wr_ready), 32'd1);
        checkOutput("abort_no_done",  32'(done),             32'd0);
        idleCycle(1'b0);

        // A write coinciding with clear must be dropped, then a full reload.
        applyStimulus(1'b1, 32'h0000_0BAD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0);
        loadKeys(0, 36);
        idleCycle(1'b0);

        // Reset mid-stream at transfer 20.
        runStream(1'b0, 1'b0, 20);
        checkOutput("rst_ntx",  32'(ntx), 32'd20);
        checkOutput("rst_obs19", obs[19], 32'h113);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrst_rk_valid", 32'(intf.rk_valid),    32'd0);
        checkOutput("midrst_rk_out",   intf.rk_out,           32'h0);
        checkOutput("midrst_busy",     32'(busy),             32'd0);
        checkOutput("midrst_done",     32'(done),             32'd0);
        checkOutput("midrst_load_err", 32'(load_err),         32'd0);
        checkOutput("midrst_wk0",      wk0_out,               32'h0);
        checkOutput("midrst_wk1",      wk1_out,               32'h0);
        checkOutput("midrst_wr_ready", 32'(intf.rk_wr_ready), 32'd1);
        #20;
        @(posedge clk);
        #3 rst_n = 1'b1;
        idleCycle(1'b0);
        idleCycle(1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
